// File: rtl/pwm_multicanal_if.sv
// Control/status bundle for the multi-channel PWM generator.
// The master side is the register/switch front end; the slave side is the PWM core.
interface pwm_multicanal_if #(
    parameter int N_CH    = 4,
    parameter int RES     = 8,
    parameter int PRESC_W = 16
);
    logic                  en;
    logic [PRESC_W-1:0]    presc;
    logic [N_CH*RES-1:0]   duty;
    logic [N_CH-1:0]       wr_en;
    logic [N_CH-1:0]       ramp_mode;
    logic [N_CH-1:0]       pwm_o;
    logic                  period_end;
    logic [N_CH-1:0]       ramping;

    modport master (
        output en, presc, duty, wr_en, ramp_mode,
        input  pwm_o, period_end, ramping
    );

    modport slave (
        input  en, presc, duty, wr_en, ramp_mode,
        output pwm_o, period_end, ramping
    );
endinterface

// File: rtl/pwm_multicanal.sv
// N_CH-channel PWM sharing one prescaler and period counter; duty changes only
// take effect at period boundaries, either directly or as a +/-1 per period fade.
module pwm_multicanal #(
    parameter int N_CH    = 4,
    parameter int RES     = 8,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_multicanal_if.slave   bus
);
    // Last count value of a period is MAX-1, i.e. all ones except the LSB.
    localparam logic [RES-1:0]     LAST_CNT = {{(RES-1){1'b1}}, 1'b0};
    localparam logic [RES-1:0]     ONE_RES  = {{(RES-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] ONE_PC   = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] pc_r;
    logic [RES-1:0]     cnt_r;
    logic [RES-1:0]     target_r      [N_CH];
    logic [RES-1:0]     active_r      [N_CH];
    logic [RES-1:0]     next_active_s [N_CH];
    logic [N_CH-1:0]    pwm_r;
    logic [N_CH-1:0]    ramping_r;
    logic               period_end_r;
    logic               tick_s;
    logic               boundary_s;

    // Tick and period-boundary detection.
    always_comb begin
        tick_s     = 1'b0;
        boundary_s = 1'b0;
        if (bus.en && (pc_r == bus.presc)) begin
            tick_s     = 1'b1;
            boundary_s = (cnt_r == LAST_CNT);
        end else begin
            tick_s     = 1'b0;
            boundary_s = 1'b0;
        end
    end

    // Per-channel active duty for the next period (direct load or one ramp step).
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            next_active_s[i] = active_r[i];
            if (!boundary_s) begin
                next_active_s[i] = active_r[i];
            end else if (!bus.ramp_mode[i]) begin
                next_active_s[i] = target_r[i];
            end else if (active_r[i] < target_r[i]) begin
                next_active_s[i] = active_r[i] + ONE_RES;
            end else if (active_r[i] > target_r[i]) begin
                next_active_s[i] = active_r[i] - ONE_RES;
            end else begin
                next_active_s[i] = active_r[i];
            end
        end
    end

    // Prescaler and period counter; disabling parks both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r  <= {PRESC_W{1'b0}};
            cnt_r <= {RES{1'b0}};
        end else if (!bus.en) begin
            pc_r  <= {PRESC_W{1'b0}};
            cnt_r <= {RES{1'b0}};
        end else if (tick_s) begin
            pc_r  <= {PRESC_W{1'b0}};
            cnt_r <= (cnt_r == LAST_CNT) ? {RES{1'b0}} : (cnt_r + ONE_RES);
        end else begin
            pc_r  <= pc_r + ONE_PC;
        end
    end

    // Target/active duty registers; a write coinciding with a boundary lands after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                target_r[i] <= {RES{1'b0}};
                active_r[i] <= {RES{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.wr_en[i]) begin
                    target_r[i] <= bus.duty[i*RES +: RES];
                end
                active_r[i] <= next_active_s[i];
            end
        end
    end

    // Registered outputs: compare, boundary pulse and ramp-in-progress flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r        <= {N_CH{1'b0}};
            ramping_r    <= {N_CH{1'b0}};
            period_end_r <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pwm_r[i]     <= bus.en && (cnt_r < active_r[i]);
                ramping_r[i] <= (active_r[i] != target_r[i]);
            end
            period_end_r <= boundary_s;
        end
    end

    assign bus.pwm_o      = pwm_r;
    assign bus.ramping    = ramping_r;
    assign bus.period_end = period_end_r;
endmodule

// File: doc/pwm_multicanal.md
Name: pwm_multicanal

Overview:
Parametrised multi-channel PWM generator. It is the successor to the single-channel, switch-driven LED PWM. It provides N_CH independent channels sharing one prescaler and one period counter, with configurable duty resolution and glitch-free duty updates at period boundaries. Each channel has an optional linear ramp (fade) mode. It sits between the board-level control registers/switch decoders and the LED/actuator pins.

Parameters:
N_CH, 4, number of PWM channels
RES, 8, duty resolution in bits; MAX = 2^RES - 1 ticks per period
PRESC_W, 16, width of the prescaler reload value

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; 0 = stop and clear counters, outputs low
presc  input  PRESC_W  prescaler reload; one tick every presc+1 clk cycles
duty  input  N_CH*RES  target duty per channel; channel i occupies bits [i*RES +: RES]
wr_en  input  N_CH  per-channel write strobe for duty
ramp_mode  input  N_CH  per channel: 0 = direct update, 1 = ramp by 1 per period
pwm_o  output  N_CH  PWM outputs, registered
period_end  output  1  one-cycle pulse at each period boundary
ramping  output  N_CH  per channel: high while active duty != target duty

Behaviour:
- Reset (async, rst_n=0): prescaler count pc, period count cnt, all target[i], active[i], pwm_o, period_end and ramping are 0.
- Prescaler: while en=1, pc increments each clk. tick=1 when pc==presc, and pc then reloads to 0. presc=0 gives tick every cycle. presc is sampled live. If presc drops below pc, pc counts through wrap-around of PRESC_W bits; this is allowed, no special handling.
- Period counter: on tick, cnt increments 0..MAX-1, then wraps to 0. Boundary = tick && cnt==MAX-1. A period is MAX ticks.
- Compare: pwm_o[i] <= en && (cnt < active[i]). One clk latency from cnt to pwm_o.
  - active=0 gives constant low.
  - active=MAX gives constant high (100%).
  - No value exceeds MAX by construction.
- Target write: wr_en[i]=1 loads target[i] <= duty slice i on that clk edge. It has no immediate effect on pwm_o.
- Boundary update, per channel, on the boundary clk edge:
  - ramp_mode[i]=0: active[i] <= target[i].
  - ramp_mode[i]=1: active[i] steps by +1 if below target[i], by -1 if above, and holds if equal.
  - ramp_mode is sampled at the boundary; switching mode mid-ramp is legal.
- Simultaneous wr_en[i] and boundary in the same cycle: the boundary uses the old target[i]. The new target is applied at the next boundary.
- period_end <= boundary. It is a single-cycle pulse, aligned with the active[] update edge.
- ramping[i] <= (active[i] != target[i]), registered. It reflects post-update values one clk after the edge that changed them.
- en=0: pc and cnt are forced to 0, pwm_o=0, period_end=0. active[] holds; target[] remains writable.
  - When en returns to 1, the first period starts at cnt=0 using the held active[]. Pending targets apply at the first boundary.
- rst_n asserted mid-period: immediate async clear of all state. After release, behaviour is identical to power-up.

Test Plan:
- RES=4 (MAX=15), N_CH=4, presc=0, en=1, direct mode. Write duty ch0=3, ch1=0, ch2=15, ch3=8. After the first period_end: per 15-cycle period, ch0 is high 3 cycles, ch1 always low, ch2 always high, ch3 high 8 cycles. period_end pulses every 15 clks.
- Prescaler: presc=2, ch0 duty=5. Period is 45 clks; ch0 high 15 consecutive clks per period; period_end spacing is 45.
- Glitch-free update: ch0 at 10. Write 4 mid-period (cnt=6). The current period still shows 10 high ticks; the next period shows 4. Write coincident with boundary: the value applies one period later.
- Ramp: ch1 ramp_mode=1, active 0, write target 5. active goes 1,2,3,4,5 over five consecutive boundaries, with high time growing 1..5 ticks. ramping[1] is high until 1 clk after the 5th boundary. Then write target 2: active steps down 4,3,2.
- en/reset: deassert en mid-period. pwm_o=0 and cnt=0 next clk; active is retained. Re-enable: the period restarts at cnt=0. Pulse rst_n low mid-ramp: all outputs 0 immediately and active/target read 0.
